// File: rtl/aes128_round_iter.sv
// aes128_round_iter: iterative AES-128 encryption core, one round per clock.
// aes128_sub_bytes: 128-bit SubBytes block (16 parallel S-boxes).
//
// Ports (aes128_round_iter):
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      encrypt request, sampled only while busy=0
//   key        128-bit cipher key, sampled on an accepted start
//   plaintext  128-bit input block, sampled on an accepted start
//   busy       high while a block is in flight
//   done       one-cycle pulse, ciphertext valid
//   ciphertext result, held until the next completion (or rst)
//
// Byte order is FIPS-197: byte i is bits [127-8i -: 8], column c holds
// bytes 4c..4c+3 with row r = byte 4c+r.

module aes128_sub_bytes (
  input  logic [127:0] din,
  output logic [127:0] dout
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    gmul = acc;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    sbox = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Substitute every byte of the input word.
  always_comb begin
    dout = 128'h0;
    for (int i = 0; i < 16; i++) begin
      dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end
  end

endmodule

module aes128_round_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} fsm_e;

  fsm_e         fsm_r, fsm_s;
  logic [127:0] state_r, rk_r, ct_r;
  logic [3:0]   round_r;
  logic         busy_r, done_r;

  logic [127:0] sb_out_s, kb_in_s, kb_out_s, sr_s, mc_s, rk_next_s, round_out_s;
  logic [31:0]  rot_s, w0n_s, w1n_s, w2n_s, w3n_s;
  logic [7:0]   rcon_s;
  logic         accept_s, last_s;
  logic         kb_unused_s;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of the 4x4 byte matrix rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // Column mix with matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  aes128_sub_bytes u_sb_state (.din(state_r), .dout(sb_out_s));
  aes128_sub_bytes u_sb_key   (.din(kb_in_s), .dout(kb_out_s));

  // Round datapath: on-the-fly key expansion and SubBytes/ShiftRows/MixColumns/AddRoundKey.
  always_comb begin
    rot_s       = {rk_r[23:0], rk_r[31:24]};
    kb_in_s     = {rot_s, 96'h0};
    rcon_s      = rcon(round_r);
    w0n_s       = rk_r[127:96] ^ kb_out_s[127:96] ^ {rcon_s, 24'h0};
    w1n_s       = rk_r[95:64] ^ w0n_s;
    w2n_s       = rk_r[63:32] ^ w1n_s;
    w3n_s       = rk_r[31:0]  ^ w2n_s;
    rk_next_s   = {w0n_s, w1n_s, w2n_s, w3n_s};
    sr_s        = shift_rows(sb_out_s);
    mc_s        = mix_columns(sr_s);
    last_s      = (round_r == 4'd10);
    // Final round skips MixColumns.
    if (last_s) begin
      round_out_s = sr_s ^ rk_next_s;
    end else begin
      round_out_s = mc_s ^ rk_next_s;
    end
    // Only the top word of the key-path SubBytes carries SubWord.
    kb_unused_s = ^kb_out_s[95:0];
  end

  // Next-state logic for the IDLE/RUN controller.
  always_comb begin
    fsm_s    = fsm_r;
    accept_s = 1'b0;
    case (fsm_r)
      IDLE: begin
        if (start) begin
          fsm_s    = RUN;
          accept_s = 1'b1;
        end else begin
          fsm_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          fsm_s = IDLE;
        end else begin
          fsm_s = RUN;
        end
      end
      default: fsm_s = IDLE;
    endcase
  end

  // Control registers and outputs; rst wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r   <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ct_r    <= 128'h0;
      round_r <= 4'd0;
    end else begin
      fsm_r  <= fsm_s;
      done_r <= 1'b0;
      case (fsm_r)
        IDLE: begin
          if (accept_s) begin
            busy_r  <= 1'b1;
            round_r <= 4'd1;
          end
        end
        RUN: begin
          if (last_s) begin
            ct_r    <= round_out_s;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            round_r <= 4'd0;
          end else begin
            round_r <= round_r + 4'd1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          round_r <= 4'd0;
        end
      endcase
    end
  end

  // Cipher state and round key; contents are meaningless outside RUN, so no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      state_r <= plaintext ^ key;
      rk_r    <= key;
    end else if (fsm_r == RUN) begin
      state_r <= round_out_s;
      rk_r    <= rk_next_s;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign ciphertext = ct_r;

endmodule

// File: tb/tb_aes128_round_iter.sv
// Self-checking bench for aes128_round_iter: FIPS-197 vectors, random blocks
// against a byte-array AES reference model, ignored start, back-to-back and
// reset abort.

module tb_aes128_round_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = 128'h0;
  logic [127:0] plaintext = 128'h0;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V2_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V2_R1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] V2_RK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_round_iter dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .plaintext(plaintext),
    .busy(busy), .done(done), .ciphertext(ciphertext)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0]  inv;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      d = {inv, inv};
      sbox_t[x] = inv ^ d[14 -: 8] ^ d[13 -: 8] ^ d[12 -: 8] ^ d[11 -: 8] ^ 8'h63;
    end
  endtask

  task automatic ref_aes(input logic [127:0] k, input logic [127:0] p,
                         output logic [127:0] ct, output logic [127:0] r1,
                         output logic [127:0] rk10);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    r1 = 128'h0;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = p[127-8*b -: 8] ^ k[127-8*b -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int b = 0; b < 16; b++) t[b] = sbox_t[s[b]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gf_mul(8'h02, a0) ^ gf_mul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gf_mul(8'h02, a1) ^ gf_mul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gf_mul(8'h02, a2) ^ gf_mul(8'h03, a3);
          s[4*c+3] = gf_mul(8'h03, a0) ^ a1 ^ a2 ^ gf_mul(8'h02, a3);
        end
      end
      for (int b = 0; b < 16; b++) begin
        tmp  = w[4*rnd + b/4];
        s[b] = s[b] ^ tmp[31-8*(b%4) -: 8];
      end
      if (rnd == 1)
        for (int b = 0; b < 16; b++) r1[127-8*b -: 8] = s[b];
    end
    for (int b = 0; b < 16; b++) ct[127-8*b -: 8] = s[b];
    rk10 = {w[40], w[41], w[42], w[43]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Start a block at the current negedge and follow it to done (bounded).
  // Inputs are scrambled after acceptance. Ends on the negedge where done=1.
  task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                           output int lat, output int busy_cyc,
                           output logic [127:0] ct, output logic [127:0] r1,
                           output logic [127:0] rk);
    key = k; plaintext = p; start = 1'b1;
    lat = 0; busy_cyc = 0; r1 = 128'h0;
    while (lat < 40) begin
      @(negedge clk);
      start = 1'b0; key = rand128(); plaintext = rand128();
      lat++;
      if (lat == 2) r1 = dut.state_r;
      if (busy && !done) busy_cyc++;
      if (done) break;
    end
    ct = ciphertext;
    rk = dut.rk_r;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got busy/done=%b required 00", {busy, done});
    end
    n_checks++;
    if (ciphertext !== 128'h0) begin
      n_fail++; $display("FAIL reset_ct: got %h required 0", ciphertext);
    end
    n_checks++;
    if (dut.round_r !== 4'd0) begin
      n_fail++; $display("FAIL reset_round: got %0d required 0", dut.round_r);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vector1();
    int lat, bc; logic [127:0] ct, r1, rk, m_ct, m_r1, m_rk;
    ref_aes(V1_KEY, V1_PT, m_ct, m_r1, m_rk);
    run_block(V1_KEY, V1_PT, lat, bc, ct, r1, rk);
    n_checks++;
    if (lat !== 11) begin n_fail++; $display("FAIL v1_latency: got %0d required 11", lat); end
    n_checks++;
    if (bc !== 10) begin n_fail++; $display("FAIL v1_busy_cycles: got %0d required 10", bc); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL v1_busy_at_done: got %b required 0", busy); end
    n_checks++;
    if (ct !== V1_CT) begin n_fail++; $display("FAIL v1_ct: got %h required %h", ct, V1_CT); end
    n_checks++;
    if (ct !== m_ct) begin n_fail++; $display("FAIL v1_ct_model: got %h required %h", ct, m_ct); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL v1_done_pulse: got %b required 0", done); end
  endtask

  task automatic test_vector2();
    int lat, bc; logic [127:0] ct, r1, rk, m_ct, m_r1, m_rk;
    ref_aes(V2_KEY, V2_PT, m_ct, m_r1, m_rk);
    @(negedge clk);
    run_block(V2_KEY, V2_PT, lat, bc, ct, r1, rk);
    n_checks++;
    if (r1 !== V2_R1 || r1 !== m_r1) begin
      n_fail++; $display("FAIL v2_round1_state: got %h required %h", r1, V2_R1);
    end
    n_checks++;
    if (rk !== V2_RK || rk !== m_rk) begin
      n_fail++; $display("FAIL v2_round10_key: got %h required %h", rk, V2_RK);
    end
    n_checks++;
    if (ct !== V2_CT || lat !== 11) begin
      n_fail++; $display("FAIL v2_ct: got %h (lat %0d) required %h (lat 11)", ct, lat, V2_CT);
    end
  endtask

  task automatic test_zero();
    int lat, bc; logic [127:0] ct, r1, rk;
    @(negedge clk);
    run_block(128'h0, 128'h0, lat, bc, ct, r1, rk);
    n_checks++;
    if (ct !== Z_CT) begin n_fail++; $display("FAIL zero_ct: got %h required %h", ct, Z_CT); end
  endtask

  task automatic test_random();
    int lat, bc; logic [127:0] k, p, ct, r1, rk, m_ct, m_r1, m_rk;
    for (int n = 0; n < 5; n++) begin
      k = rand128(); p = rand128();
      ref_aes(k, p, m_ct, m_r1, m_rk);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      run_block(k, p, lat, bc, ct, r1, rk);
      n_checks++;
      if (ct !== m_ct || lat !== 11) begin
        n_fail++; $display("FAIL random_ct[%0d]: got %h (lat %0d) required %h (lat 11)", n, ct, lat, m_ct);
      end
    end
  endtask

  task automatic test_ignored_start();
    int dones, done_lat; bit held;
    @(negedge clk);
    key = V1_KEY; plaintext = V1_PT; start = 1'b1;
    dones = 0; done_lat = 0;
    for (int lat = 1; lat <= 11; lat++) begin
      @(negedge clk);
      start = (lat == 3 || lat == 7);
      key = rand128(); plaintext = rand128();
      if (done) begin dones++; done_lat = lat; end
    end
    start = 1'b0;
    n_checks++;
    if (done_lat !== 11 || ciphertext !== V1_CT) begin
      n_fail++; $display("FAIL ignored_start_ct: got %h (done at %0d) required %h (done at 11)",
                         ciphertext, done_lat, V1_CT);
    end
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (ciphertext !== V1_CT) held = 1'b0;
    end
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL ignored_start_dones: got %0d required 1", dones); end
    n_checks++;
    if (held !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ct_hold_idle: got held=%b busy=%b required held=1 busy=0", held, busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [127:0] ct, r1, rk;
    @(negedge clk);
    run_block(V1_KEY, V1_PT, lat, bc, ct, r1, rk);
    n_checks++;
    if (ct !== V1_CT) begin n_fail++; $display("FAIL b2b_first_ct: got %h required %h", ct, V1_CT); end
    run_block(V2_KEY, V2_PT, lat, bc, ct, r1, rk);
    n_checks++;
    if (lat !== 11 || bc !== 10) begin
      n_fail++; $display("FAIL b2b_latency: got lat %0d busy %0d required 11 and 10", lat, bc);
    end
    n_checks++;
    if (ct !== V2_CT) begin n_fail++; $display("FAIL b2b_second_ct: got %h required %h", ct, V2_CT); end
  endtask

  task automatic test_reset_abort();
    int lat, bc, dones; logic [127:0] ct, r1, rk;
    @(negedge clk);
    key = V1_KEY; plaintext = V1_PT; start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b00 || ciphertext !== 128'h0) begin
      n_fail++; $display("FAIL abort_outputs: got busy/done=%b ct=%h required 00 and 0",
                         {busy, done}, ciphertext);
    end
    dones = 0;
    repeat (20) begin @(negedge clk); if (done || busy) dones++; end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles required 0", dones); end
    run_block(V1_KEY, V1_PT, lat, bc, ct, r1, rk);
    n_checks++;
    if (ct !== V1_CT || lat !== 11) begin
      n_fail++; $display("FAIL abort_restart_ct: got %h (lat %0d) required %h (lat 11)", ct, lat, V1_CT);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_vector1();
    test_vector2();
    test_zero();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
